// File: rtl/avion_prog_loader_pkg.sv
// Shared types and defaults for the avion program loader.
// The loader streams a boot image into blram and holds the CPU in reset while it does so.
package avion_prog_loader_pkg;

  localparam int unsigned DEF_AW = 6;
  localparam int unsigned DEF_DW = 10;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_COUNT = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  // A count byte of 0 means a full RAM; anything above the RAM size saturates to it.
  function automatic int unsigned words_from_count(input logic [BYTE_W-1:0] cnt,
                                                   input int unsigned aw);
    int unsigned cap;
    int unsigned n;
    cap = 32'd1 << aw;
    n   = 32'(cnt);
    if (n == 0 || n > cap) begin
      return cap;
    end
    return n;
  endfunction

endpackage

// File: rtl/avion_prog_loader_byte_packer.sv
// Packs a lo/hi byte pair into one RAM word.
// Bits of the hi byte that do not fit in the word are dropped.
module avion_prog_loader_byte_packer
  import avion_prog_loader_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_byte_i,
  input  logic              lo_en_i,
  input  logic              hi_en_i,
  output logic [DW-1:0]     word_o
);

  logic [BYTE_W-1:0] lo_q;
  logic [DW-1:0]     word_q;
  logic [DW-1:0]     word_d;

  generate
    if (DW > BYTE_W) begin : g_wide
      always_comb word_d = {in_byte_i[DW-BYTE_W-1:0], lo_q};
    end else begin : g_narrow
      always_comb word_d = lo_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      word_q <= '0;
    end else begin
      if (lo_en_i) lo_q <= in_byte_i;
      if (hi_en_i) word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/avion_prog_loader.sv
// Boot loader: receives a counted, checksummed byte stream, writes it to blram from
// address 0 and releases avion_cpu from reset only once the checksum verifies.
module avion_prog_loader
  import avion_prog_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_AW,
  parameter int unsigned DATA_WIDTH    = DEF_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     restart,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     last_q, last_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              we_q, we_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              lo_en;
  logic              hi_en;

  assign in_ready = rst & ((state_q == ST_COUNT) | (state_q == ST_LO) |
                           (state_q == ST_HI)    | (state_q == ST_CSUM));
  assign accept   = in_valid & in_ready;
  assign lo_en    = accept & (state_q == ST_LO);
  assign hi_en    = accept & (state_q == ST_HI);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_COUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COUNT: if (accept) state_d = ST_LO;
      ST_LO:    if (accept) state_d = ST_HI;
      ST_HI:    if (accept) state_d = ST_WRITE;
      ST_WRITE: state_d = (addr_q == last_q) ? ST_CSUM : ST_LO;
      ST_CSUM:  if (accept) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      ST_DONE:  if (restart) state_d = ST_COUNT;
      ST_ERR:   if (restart) state_d = ST_COUNT;
      default:  state_d = ST_COUNT;
    endcase
  end

  // Outputs follow the state being entered so they are valid the cycle it is occupied
  always_comb begin
    we_d      = (state_d == ST_WRITE);
    cpu_rst_d = (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
  end

  // Address counter, word-count limit and running checksum
  always_comb begin
    addr_d = addr_q;
    last_d = last_q;
    csum_d = csum_q;
    case (state_q)
      ST_COUNT: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          last_d = AW'(words_from_count(in_data, AW) - 32'd1);
        end
      end
      ST_LO, ST_HI: begin
        if (accept) csum_d = csum_q ^ in_data;
      end
      ST_WRITE: begin
        if (addr_q != last_q) addr_d = addr_q + AW'(1);
      end
      ST_DONE, ST_ERR: begin
        if (restart) begin
          addr_d = '0;
          csum_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      last_q    <= '0;
      csum_q    <= '0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      last_q    <= last_d;
      csum_q    <= csum_d;
      we_q      <= we_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  avion_prog_loader_byte_packer #(
    .DW(DW)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst),
    .in_byte_i (in_data),
    .lo_en_i   (lo_en),
    .hi_en_i   (hi_en),
    .word_o    (ram_wdata)
  );

  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_avion_prog_loader.sv
// Directed bench for avion_prog_loader; the bench acts as the blram and byte source.
module tb_avion_prog_loader;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 10;
  localparam logic [DW-1:0] SENT = 10'h155;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          restart = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [64];
  int            we_cnt = 0;
  int            addr0_cnt = 0;
  int            rdy_viol = 0;
  logic [7:0]    stream [$];

  avion_prog_loader #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .restart  (restart),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // RAM model and write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      mem[ram_addr] = ram_wdata;
      we_cnt++;
      if (ram_addr == '0) addr0_cnt++;
      if (in_ready !== 1'b0) rdy_viol++;
    end
  end

  task automatic clear_ram();
    for (int i = 0; i < 64; i++) mem[i] = SENT;
    we_cnt    = 0;
    addr0_cnt = 0;
    rdy_viol  = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    budget = 0;
    @(negedge clk);
    if (gaps) begin
      while ($urandom_range(0, 1) == 0 && budget < 20) begin
        in_valid = 1'b0;
        @(negedge clk);
        budget++;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    budget   = 0;
    while (in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: in_ready=%b after %0d cycles, required 1", in_ready, budget);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_stream(input bit gaps);
    foreach (stream[k]) send_byte(stream[k], gaps);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic build_img1(input logic [7:0] csum);
    stream = '{8'h04, 8'h32, 8'h00, 8'hB3, 8'h00, 8'h74, 8'h00, 8'h40, 8'h02, csum};
  endtask

  task automatic check_img1(input string tag);
    logic [DW-1:0] exp_w [4];
    exp_w = '{10'h032, 10'h0B3, 10'h074, 10'h240};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL %s_ram%0d: got %h expected %h", tag, i, mem[i], exp_w[i]);
      end
    end
    checks++;
    if (we_cnt !== 4) begin
      errors++;
      $display("FAIL %s_we_count: got %0d expected 4", tag, we_cnt);
    end
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: done=%b cpu_rst=%b err=%b expected 1 0 0", tag, done, cpu_rst, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0 ||
        cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b we=%b addr=%h wd=%h cpu_rst=%b done=%b err=%b expected 0 0 00 000 1 0 0",
               in_ready, ram_we, ram_addr, ram_wdata, cpu_rst, done, err);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: in_ready=%b cpu_rst=%b expected 1 1", in_ready, cpu_rst);
    end
  endtask

  task automatic test_basic_load();
    clear_ram();
    build_img1(8'hB3);
    send_stream(1'b0);
    check_img1("basic");
    checks++;
    if (mem[52] !== SENT) begin
      errors++;
      $display("FAIL basic_ram52: got %h expected %h", mem[52], SENT);
    end
  endtask

  task automatic test_bad_csum();
    pulse_restart();
    clear_ram();
    build_img1(8'hB2);
    send_stream(1'b0);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL badcsum_status: err=%b done=%b cpu_rst=%b expected 1 0 1", err, done, cpu_rst);
    end
    pulse_restart();
    checks++;
    if (err !== 1'b0 || cpu_rst !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL badcsum_restart: err=%b cpu_rst=%b in_ready=%b expected 0 1 1", err, cpu_rst, in_ready);
    end
    clear_ram();
    build_img1(8'hB3);
    send_stream(1'b0);
    check_img1("reload");
  endtask

  task automatic test_gapped_valid();
    pulse_restart();
    clear_ram();
    build_img1(8'hB3);
    send_stream(1'b1);
    check_img1("gapped");
    checks++;
    if (rdy_viol !== 0) begin
      errors++;
      $display("FAIL gapped_ready_in_write: got %0d violations expected 0", rdy_viol);
    end
  endtask

  task automatic test_full_image();
    pulse_restart();
    clear_ram();
    stream = {};
    stream.push_back(8'h00);
    for (int i = 0; i < 64; i++) begin
      stream.push_back(8'(i));
      stream.push_back(8'h00);
    end
    stream.push_back(8'h00);
    send_stream(1'b0);
    checks++;
    if (mem[63] !== 10'h03F || mem[31] !== 10'h01F || mem[0] !== 10'h000) begin
      errors++;
      $display("FAIL full_ram: m63=%h m31=%h m0=%h expected 03f 01f 000", mem[63], mem[31], mem[0]);
    end
    checks++;
    if (we_cnt !== 64 || addr0_cnt !== 1) begin
      errors++;
      $display("FAIL full_writes: we=%0d addr0=%0d expected 64 1", we_cnt, addr0_cnt);
    end
    checks++;
    if (done !== 1'b1 || ram_addr !== 6'd63 || rdy_viol !== 0) begin
      errors++;
      $display("FAIL full_status: done=%b addr=%0d rdyviol=%0d expected 1 63 0", done, ram_addr, rdy_viol);
    end
  endtask

  task automatic test_reset_midload();
    pulse_restart();
    clear_ram();
    build_img1(8'hB3);
    for (int k = 0; k < 7; k++) send_byte(stream[k], 1'b0);
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("FAIL midload_write_pending: ram_we=%b expected 1", ram_we);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 ||
        ram_addr !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midload_async_reset: we=%b cpu_rst=%b done=%b err=%b addr=%h rdy=%b expected 0 1 0 0 00 0",
               ram_we, cpu_rst, done, err, ram_addr, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_ram();
    send_stream(1'b0);
    check_img1("afterrst");
  endtask

  task automatic test_restart_ignored();
    pulse_restart();
    clear_ram();
    build_img1(8'hB3);
    send_byte(stream[0], 1'b0);
    pulse_restart();
    for (int k = 1; k < 10; k++) send_byte(stream[k], 1'b0);
    check_img1("restart_in_lo");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_csum();
    test_gapped_valid();
    test_full_image();
    test_reset_midload();
    test_restart_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
